// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch front end and controlLogic.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_EXEC = 2'd1,
        FETCH_ERR  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned TIMEOUT_DEFAULT  = 16;

    // MIPS primary opcodes shared with controlLogic
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles an instruction fetch has waited for an ack.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] wait_cnt;

    // Wait counter: cleared by reset or a completed handshake, advances while waiting
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign expire = enable && (wait_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, fetches via req/ack, holds inst until retired.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic [31:0] next_pc,
    output logic        fetch_err,
    output logic [31:0] retire_cnt
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         handshake;
    logic         wait_en;
    logic         wait_expire;

    assign handshake = imem_req && imem_ack;
    assign wait_en   = (state_q == FETCH_REQ) && !handshake;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (handshake),
        .enable (wait_en),
        .expire (wait_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack on the timeout cycle takes priority over the error
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_REQ: begin
                if (handshake) begin
                    state_d = FETCH_EXEC;
                end else if (wait_expire) begin
                    state_d = FETCH_ERR;
                end
            end
            FETCH_EXEC: begin
                if (exec_done) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_ERR: state_d = FETCH_ERR;
            default:   state_d = FETCH_REQ;
        endcase
    end

    // Registered outputs, PC and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_req   <= 1'b1;
            imem_addr  <= RESET_PC;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (handshake) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                    end else if (wait_expire) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                    end
                end
                FETCH_EXEC: begin
                    if (exec_done) begin
                        pc         <= next_pc;
                        imem_addr  <= next_pc;
                        imem_req   <= 1'b1;
                        inst_valid <= 1'b0;
                        retire_cnt <= retire_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Sequential instruction-fetch front end of the single-cycle MIPS datapath.
- Owns the architectural PC and fetches each word from instruction memory through a req/ack handshake.
- Presents inst/pc to controlLogic and holds them until execution completes.
- On completion, loads next_pc from controlLogic and starts the next fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles imem_req may stay high without imem_ack before a fetch error (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc while imem_req=1.
- imem_ack  input  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction word.
- inst  output  32  instruction to controlLogic.
- pc  output  32  PC of inst, to controlLogic.
- inst_valid  output  1  inst/pc valid and stable.
- exec_done  input  1  controlLogic/writeback finished; next_pc valid this cycle.
- next_pc  input  32  successor PC computed by controlLogic.
- fetch_err  output  1  sticky fetch timeout flag.
- retire_cnt  output  32  count of completed instructions.

Behaviour:
- All outputs are registered. No combinational input-to-output paths.
- Reset values:
  - state=REQ, imem_req=1, imem_addr=RESET_PC, pc=RESET_PC
  - inst=0, inst_valid=0, fetch_err=0, retire_cnt=0, wait_cnt=0
  - The first request is visible in the first cycle after rst deasserts.
- States: REQ, EXEC, ERR.
- REQ state:
  - imem_req=1 and imem_addr=pc, both held stable.
  - A handshake completes on an edge where imem_req=1 and imem_ack=1. On that edge:
    - inst<=imem_rdata, inst_valid<=1, imem_req<=0, wait_cnt<=0, goto EXEC.
  - No ack: wait_cnt increments.
  - If wait_cnt==TIMEOUT-1 and no ack: imem_req<=0, fetch_err<=1, goto ERR.
  - An ack on the timeout cycle wins (handshake completes, no error).
  - imem_ack while imem_req=0 is ignored.
- EXEC state:
  - inst_valid=1; inst and pc hold their values.
  - exec_done=1: pc<=next_pc, imem_addr<=next_pc, imem_req<=1, inst_valid<=0, retire_cnt<=retire_cnt+1, goto REQ.
  - exec_done=0: hold.
  - exec_done is ignored in REQ and ERR.
- ERR state:
  - imem_req=0, inst_valid=0, fetch_err=1, all other state frozen.
  - Left only by rst.
- next_pc is taken verbatim. No alignment check or masking; byte/word interpretation belongs to controlLogic.
- retire_cnt wraps modulo 2^32 (32'hFFFF_FFFF+1=0).
- Throughput: minimum 2 cycles per instruction (1 REQ cycle with immediate ack + 1 EXEC cycle with immediate exec_done).
- rst mid-operation (in REQ with an outstanding request, EXEC, or ERR) aborts everything. The next cycle shows the reset values; any later ack for the aborted request is not captured unless it lands in the new REQ cycle.

Decomposition:
- Shared package / include file:
  - state encodings FETCH_REQ=2'd0, FETCH_EXEC=2'd1, FETCH_ERR=2'd2
  - RESET_PC default
  - MIPS opcode constants shared with controlLogic (R-type 6'h00, beq 6'h04, bne 6'h05, addi/andi, lw 6'h23, sw 6'h2B, j 6'h02).
- One natural sub-module: fetch_timeout_ctr, the wait counter with clear/enable/expire outputs.
- FSM, PC register and retire counter stay in inst_fetch.

Test Plan:
- Reset, then memory acks the first cycle of req with 32'h0022_9821:
  - imem_addr=0 during req; next cycle inst=32'h0022_9821, pc=0, inst_valid=1.
- In EXEC, hold exec_done=0 for 5 cycles, then pulse with next_pc=12:
  - inst/pc stable all 5 cycles.
  - Next cycle imem_req=1, imem_addr=12, inst_valid=0, retire_cnt=1.
- Ack delayed 3 cycles on a fetch from 32'h0000_000D (TIMEOUT=16):
  - imem_req/imem_addr held 4 cycles; fetch completes, no error.
- Never ack with TIMEOUT=4:
  - after the 4th req cycle imem_req=0, fetch_err=1.
  - exec_done and imem_ack afterwards have no effect.
  - rst clears to pc=RESET_PC with fetch_err=0.
- Run the six-instruction stream (R, andi, beq, lw, sw, j) with back-to-back ack and exec_done, next_pc sequence 4,12,13,14,20,13:
  - retire_cnt=6, each pc matches the previous next_pc, 2 cycles per instruction.
- Assert rst in EXEC with pc=20:
  - next cycle pc=0, inst_valid=0, retire_cnt=0, imem_req=1.
